// File: rtl/cpu_bus_pkg.sv
// Purpose : shared definitions for the CPU memory-side bus blocks (SRAM arbiter, later the AXI bridge).
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package cpu_bus_pkg;

  // Arbiter FSM encoding, 2 bits wide.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Which requester owns the outstanding transaction.
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // Byte-strobe width for a given data width.
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter.sv
// Purpose : shares one SRAM-like bus between instruction fetch and load/store, one transaction outstanding.
// Latency : addr_ok same cycle as grant (T), bus_req at T+1, earliest data_ok at T+2, next grant at T+3.
// Backpr. : requests are acknowledged only in IDLE; requesters hold req and fields until their addr_ok.
// Ports   : clk/resetn; inst_* fetch port; data_* load/store port; bus_* single memory port.
module sram_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  localparam int STRB_W    = strb_w(DATA_W)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [STRB_W-1:0] bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] SKIP_MAX = CNT_W'(STARVE_MAX);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  skip_cnt_q, skip_cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              wr_q, wr_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant_inst;

  // Data normally wins a tie; once it has beaten a waiting fetch STARVE_MAX times in a row, fetch wins.
  assign grant_inst = inst_req & (~data_req | (skip_cnt_q == SKIP_MAX));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    skip_cnt_d   = skip_cnt_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // resetn gate keeps the combinational acks quiet while reset is held.
        if (resetn && (inst_req || data_req)) begin
          state_d = ST_REQ;
          if (grant_inst) begin
            inst_addr_ok = 1'b1;
            owner_d      = OWNER_INST;
            skip_cnt_d   = '0;
            wr_d         = 1'b0;
            wstrb_d      = '0;
            addr_d       = inst_addr;
            wdata_d      = '0;
          end else begin
            data_addr_ok = 1'b1;
            owner_d      = OWNER_DATA;
            wr_d         = data_wr;
            wstrb_d      = data_wstrb;
            addr_d       = data_addr;
            wdata_d      = data_wdata;
            if (inst_req && (skip_cnt_q != SKIP_MAX)) skip_cnt_d = skip_cnt_q + 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (bus_addr_ok) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus_data_ok) begin
          state_d      = ST_IDLE;
          inst_data_ok = (owner_q == OWNER_INST);
          data_data_ok = (owner_q == OWNER_DATA);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // bus_req is registered so it follows the state register exactly.
    bus_req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWNER_INST;
      skip_cnt_q <= '0;
      bus_req_q  <= 1'b0;
      wr_q       <= 1'b0;
      wstrb_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      skip_cnt_q <= skip_cnt_d;
      bus_req_q  <= bus_req_d;
      wr_q       <= wr_d;
      wstrb_q    <= wstrb_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_wr     = wr_q;
  assign bus_wstrb  = wstrb_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Purpose : randomized and directed bench for sram_bus_arbiter against a transaction-level model.
// Latency : model predicts acks per cycle from the arbitration and handshake rules.
// Backpr. : bench requesters hold req until their addr_ok; bench slave stalls addr_ok/data_ok randomly.
module tb_sram_bus_arbiter;

  localparam int AW = 32, DW = 32, SW = 4, SMAX = 4;

  logic          clk, resetn;
  logic          inst_req, inst_addr_ok, inst_data_ok;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr, data_addr_ok, data_data_ok;
  logic [SW-1:0] data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [SW-1:0] bus_wstrb;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;

  sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Transaction-level model: one outstanding transfer, its owner, whether the slave took it,
  // and how many consecutive data wins a waiting fetch has suffered.
  bit            m_busy, m_acc, m_own;
  int            m_skips;
  logic          m_wr;
  logic [SW-1:0] m_wstrb;
  logic [AW-1:0] m_addr, m_wdata;

  bit last_ia, last_da, s_pend;
  int run_da, last_run, n_ia, n_da, n_idok, n_ddok, n_breq;
  int p_inst, p_data, p_aok, p_dok, p_spur;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_own = 0; m_skips = 0;
    m_wr = 0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
    s_pend = 0; run_da = 0;
  endtask

  // Called mid-cycle: compares outputs, then advances the model across the coming edge.
  task automatic check_cycle();
    bit e_ia, e_da, e_breq, e_idok, e_ddok;
    e_ia = 0; e_da = 0;
    if (!resetn) model_reset();
    else if (!m_busy && (inst_req || data_req)) begin
      if (inst_req && (!data_req || m_skips >= SMAX)) e_ia = 1;
      else e_da = 1;
    end
    e_breq = m_busy && !m_acc;
    e_idok = resetn && m_busy && m_acc && bus_data_ok && !m_own;
    e_ddok = resetn && m_busy && m_acc && bus_data_ok && m_own;

    chk("inst_addr_ok", 64'(inst_addr_ok), 64'(e_ia));
    chk("data_addr_ok", 64'(data_addr_ok), 64'(e_da));
    chk("bus_req", 64'(bus_req), 64'(e_breq));
    chk("inst_data_ok", 64'(inst_data_ok), 64'(e_idok));
    chk("data_data_ok", 64'(data_data_ok), 64'(e_ddok));
    if (e_breq) begin
      chk("bus_wr", 64'(bus_wr), 64'(m_wr));
      chk("bus_wstrb", 64'(bus_wstrb), 64'(m_wstrb));
      chk("bus_addr", 64'(bus_addr), 64'(m_addr));
      chk("bus_wdata", 64'(bus_wdata), 64'(m_wdata));
    end
    if (e_idok) chk("inst_rdata", 64'(inst_rdata), 64'(bus_rdata));
    if (e_ddok) chk("data_rdata", 64'(data_rdata), 64'(bus_rdata));

    last_ia = inst_addr_ok;
    last_da = data_addr_ok;
    if (inst_addr_ok) begin n_ia++; last_run = run_da; run_da = 0; end
    if (data_addr_ok) begin n_da++; run_da++; end
    if (inst_data_ok) n_idok++;
    if (data_data_ok) n_ddok++;
    if (bus_req) n_breq++;
    if (s_pend && bus_data_ok) s_pend = 0;
    else if (bus_req && bus_addr_ok) s_pend = 1;

    if (e_ia) begin
      m_busy = 1; m_acc = 0; m_own = 0; m_skips = 0;
      m_wr = 0; m_wstrb = '0; m_addr = inst_addr; m_wdata = '0;
    end else if (e_da) begin
      m_busy = 1; m_acc = 0; m_own = 1;
      m_wr = data_wr; m_wstrb = data_wstrb; m_addr = data_addr; m_wdata = data_wdata;
      if (inst_req && m_skips < SMAX) m_skips++;
    end else if (e_breq && bus_addr_ok) m_acc = 1;
    else if (e_idok || e_ddok) m_busy = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  // Bench requesters and slave for one cycle, driven just after the active edge.
  task automatic drive();
    if (last_ia) inst_req = 0;
    if (last_da) data_req = 0;
    if (!inst_req && $urandom_range(99) < p_inst) begin
      inst_req = 1; inst_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!data_req && $urandom_range(99) < p_data) begin
      data_req = 1; data_wr = 1'($urandom); data_wstrb = 4'($urandom);
      data_addr = $urandom; data_wdata = $urandom;
    end
    bus_addr_ok = bus_req ? ($urandom_range(99) < p_aok) : 1'b0;
    bus_data_ok = s_pend ? ($urandom_range(99) < p_dok) : ($urandom_range(99) < p_spur);
    bus_rdata = $urandom;
  endtask

  initial begin
    int d0, i0, guard, b0;
    resetn = 0; inst_req = 0; inst_addr = '0; data_req = 0; data_wr = 0; data_wstrb = '0;
    data_addr = '0; data_wdata = '0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
    p_inst = 0; p_data = 0; p_aok = 0; p_dok = 0; p_spur = 0;
    last_ia = 0; last_da = 0; last_run = -1;
    n_ia = 0; n_da = 0; n_idok = 0; n_ddok = 0; n_breq = 0;
    model_reset();
    repeat (3) cycle();
    resetn = 1;

    // Lone fetch with a zero-wait slave: grant T, bus_req T+1, data T+2.
    inst_req = 1; inst_addr = 32'h1C00_0000;
    cycle();
    inst_req = 0; bus_addr_ok = 1; cycle();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0280_0421; cycle();
    bus_data_ok = 0;
    chk("t2_inst_data_ok_count", 64'(n_idok), 64'd1);
    chk("t2_data_data_ok_count", 64'(n_ddok), 64'd0);
    cycle();

    // Simultaneous fetch and store: store first, fetch on the next IDLE.
    d0 = n_da; i0 = n_ia;
    inst_req = 1; inst_addr = 32'h1C00_0004;
    data_req = 1; data_wr = 1; data_addr = 32'h1C00_8000; data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'hF;
    p_aok = 100; p_dok = 100;
    cycle();
    chk("t3_first_grant_data", 64'(n_da - d0), 64'd1);
    chk("t3_fetch_waits", 64'(n_ia - i0), 64'd0);
    repeat (8) begin drive(); cycle(); end
    chk("t3_fetch_granted", 64'(n_ia - i0), 64'd1);

    // Load left outstanding in WAIT, then reset drops everything.
    data_req = 1; data_wr = 0; data_addr = 32'h1C00_0100; p_dok = 0;
    cycle();
    drive(); cycle();
    drive(); cycle();
    resetn = 0; bus_data_ok = 1; #1;
    chk("t1_reset_bus_req", 64'(bus_req), 64'd0);
    chk("t1_reset_oks", 64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 64'd0);
    cycle(); cycle();
    bus_data_ok = 0; resetn = 1;
    last_ia = 0; last_da = 0;

    // Starvation: both always requesting; fetch gets in after exactly SMAX data wins,
    // starting from the cleared post-reset count.
    p_inst = 100; p_data = 100; p_aok = 100; p_dok = 100;
    for (int k = 0; k < 3; k++) begin
      guard = 0;
      do begin drive(); cycle(); guard++; end while (!last_ia && guard < 200);
      chk("t4_starve_bound", 64'(guard < 200), 64'd1);
      chk("t4_data_wins", 64'(last_run), 64'(SMAX));
    end

    // Slave stall: addr_ok held low for 5 cycles.
    p_inst = 0; p_data = 0;
    repeat (6) begin drive(); cycle(); end
    inst_req = 1; inst_addr = 32'h1C00_0040; p_aok = 0;
    i0 = n_ia;
    cycle();
    b0 = n_breq;
    repeat (5) begin drive(); cycle(); end
    chk("t5_stall_bus_req_cycles", 64'(n_breq - b0), 64'd5);
    chk("t5_no_repulse", 64'(n_ia - i0), 64'd1);
    p_aok = 100;
    repeat (4) begin drive(); cycle(); end

    // Spurious bus_data_ok in IDLE and REQ.
    p_spur = 100; p_aok = 30; p_data = 40;
    repeat (40) begin drive(); cycle(); end
    p_spur = 0;

    // Random traffic with a reset in the middle.
    for (int r = 0; r < 14; r++) begin
      p_inst = $urandom_range(100); p_data = $urandom_range(100);
      p_aok = $urandom_range(20, 100); p_dok = $urandom_range(20, 100);
      p_spur = $urandom_range(30);
      repeat (200) begin drive(); cycle(); end
      if (r == 7) begin
        resetn = 0; cycle(); cycle(); resetn = 1;
        last_ia = 0; last_da = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
